// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - packs an 8-bit byte stream into 64-bit words and writes them to the data RAM wide port.
// Optional byte checksum accumulator: define RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter int WORDS  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mode,
    output logic              we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [63:0]       ext_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            state;
    logic [2:0]        byte_cnt;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       shreg;

    // The shift register only moves in FILL, so it holds the packed word through WRITE.
    assign ext_data = shreg;
    assign ext_addr = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            addr     <= '0;
            shreg    <= '0;
            in_ready <= 1'b0;
            mode     <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        byte_cnt <= '0;
                        addr     <= '0;
                        in_ready <= 1'b1;
                        mode     <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        shreg    <= {shreg[55:0], in_data};
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            we       <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    we <= 1'b0;
                    if (addr == LAST_ADDR) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        addr     <= addr + 1'b1;
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    mode  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (state == IDLE && start) begin
            sum <= '0;
        end else if (state == FILL && in_valid) begin
            sum <= sum + in_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader against a word-level reference model.
`timescale 1ns/1ps
module tb_ram_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel, start, in_valid;
    logic [7:0] in_data;

    logic        b_in_ready, b_mode, b_we, b_busy, b_done;
    logic [6:0]  b_ext_addr;
    logic [63:0] b_ext_data;
    logic [7:0]  b_checksum;
    logic        s_in_ready, s_mode, s_we, s_busy, s_done;
    logic [6:0]  s_ext_addr;
    logic [63:0] s_ext_data;
    logic [7:0]  s_checksum;

    logic b_start, b_valid, s_start, s_valid;
    assign b_start = start & ~sel;
    assign b_valid = in_valid & ~sel;
    assign s_start = start & sel;
    assign s_valid = in_valid & sel;

    ram_loader #(.WORDS(128), .ADDR_W(7)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(in_data),
        .in_ready(b_in_ready), .mode(b_mode), .we(b_we), .ext_addr(b_ext_addr),
        .ext_data(b_ext_data), .busy(b_busy), .done(b_done), .checksum(b_checksum)
    );

    ram_loader #(.WORDS(2), .ADDR_W(7)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_data(in_data),
        .in_ready(s_in_ready), .mode(s_mode), .we(s_we), .ext_addr(s_ext_addr),
        .ext_data(s_ext_data), .busy(s_busy), .done(s_done), .checksum(s_checksum)
    );

    logic        o_in_ready, o_mode, o_we, o_busy, o_done;
    logic [6:0]  o_ext_addr;
    logic [63:0] o_ext_data;
    logic [7:0]  o_checksum;
    assign o_in_ready = sel ? s_in_ready : b_in_ready;
    assign o_mode     = sel ? s_mode     : b_mode;
    assign o_we       = sel ? s_we       : b_we;
    assign o_busy     = sel ? s_busy     : b_busy;
    assign o_done     = sel ? s_done     : b_done;
    assign o_ext_addr = sel ? s_ext_addr : b_ext_addr;
    assign o_ext_data = sel ? s_ext_data : b_ext_data;
    assign o_checksum = sel ? s_checksum : b_checksum;

    // Model of the 128x64 RAM behind the large loader's wide port.
    logic [63:0] ram [0:127];
    always @(posedge clk) if (b_we) ram[b_ext_addr] <= b_ext_data;

    logic [7:0] stream [0:1023];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int w);
        logic [63:0] r = 64'd0;
        for (int k = 0; k < 8; k++) r = r | (64'(stream[8*w+k]) << (56 - 8*k));
        return r;
    endfunction

    function automatic logic [7:0] exp_sum(input int nbytes);
        int s = 0;
`ifdef RAM_LOADER_CHECKSUM_EN
        for (int i = 0; i < nbytes; i++) s += stream[i];
`endif
        return 8'(s % 256);
    endfunction

    task automatic run_load(input logic which, input int words, input int gap_pct, input bit poke_start);
        int idx = 0;
        int wcount = 0;
        int cyc = 0;
        bit seen_done = 0;
        sel = which;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; cyc = 1;
        check("idle_ready", o_in_ready, 0);
        for (int t = 0; t < 20000 && !seen_done; t++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            check("busy_load", o_busy, 1);
            check("mode_load", o_mode, 1);
`ifndef RAM_LOADER_CHECKSUM_EN
            check("cks_zero", o_checksum, 0);
`endif
            if (o_we) begin
                check("we_ready_low", o_in_ready, 0);
                check("we_addr", o_ext_addr, 64'(wcount));
                check("we_data", o_ext_data, word_of(wcount));
                check("we_bytes", idx, 8*(wcount+1));
                wcount++;
            end
            if (o_done) begin
                seen_done = 1;
                check("we_count", wcount, words);
                check("done_ready_low", o_in_ready, 0);
                if (gap_pct == 0) check("load_cycles", cyc, 9*words + 2);
                check("done_cks", o_checksum, exp_sum(8*words));
                in_valid = 1'b0;
                if (poke_start) start = 1'b1;
            end else begin
                in_valid = ($urandom_range(99) >= gap_pct);
                in_data  = stream[idx < 1024 ? idx : 1023];
                if (in_valid && o_in_ready) idx++;
                if (poke_start && $urandom_range(9) == 0) start = 1'b1;
            end
        end
        check("done_seen", seen_done, 1);
        @(negedge clk);
        start = 1'b0;
        check("post_done", o_done, 0);
        check("post_busy", o_busy, 0);
        check("post_mode", o_mode, 0);
        check("post_ready", o_in_ready, 0);
        check("post_cks", o_checksum, exp_sum(8*words));
    endtask

    int fed, nwe;

    initial begin
        rst = 1'b1; sel = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", b_in_ready, 0);
        check("rst_mode", b_mode, 0);
        check("rst_we", b_we, 0);
        check("rst_addr", b_ext_addr, 0);
        check("rst_data", b_ext_data, 0);
        check("rst_busy", b_busy | s_busy, 0);
        check("rst_done", b_done | s_done, 0);
        check("rst_cks", b_checksum, 0);
        rst = 1'b0;

        // Reset in the middle of a word, then a fresh word must carry no stale bytes.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        fed = 0;
        while (fed < 3) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(fed);
            if (b_in_ready) fed++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ready", b_in_ready, 0);
        check("arst_mode", b_mode, 0);
        check("arst_busy", b_busy, 0);
        check("arst_data", b_ext_data, 0);
        check("arst_cks", b_checksum, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        fed = 0; nwe = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (b_we) begin
                nwe++;
                check("rr_addr", b_ext_addr, 0);
                check("rr_data", b_ext_data, 64'h1011121314151617);
            end
            in_valid = (fed < 8);
            in_data  = 8'h10 + 8'(fed);
            if (in_valid && b_in_ready) fed++;
        end
        in_valid = 1'b0;
        check("rr_we_count", nwe, 1);
        check("rr_busy", b_busy, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Two-word load with continuous bytes 0x00..0x0F.
        for (int i = 0; i < 16; i++) stream[i] = 8'(i);
        run_load(1'b1, 2, 0, 1'b0);

        // Two-word load with random data, gaps and stray start pulses.
        for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
        run_load(1'b1, 2, 40, 1'b1);

        // Full 128-word load of (i mod 256) with random gaps and stray start pulses.
        for (int i = 0; i < 1024; i++) stream[i] = 8'(i % 256);
        run_load(1'b0, 128, 25, 1'b1);
        check("readback_b9", ram[9 >> 3][63 - 8*(9 & 7) -: 8], stream[9]);
        check("readback_last", ram[127], word_of(127));

        // Full load again with random data and no gaps for exact cycle count.
        for (int i = 0; i < 1024; i++) stream[i] = 8'($urandom);
        run_load(1'b0, 128, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Byte-stream loader that fills the 128×64 data RAM through its external wide-write port before the CNN/CPU runs. It accepts 8-bit bytes over a valid/ready handshake, packs eight consecutive bytes into one 64-bit word with the first byte in bits [63:56], and writes each word to sequential word addresses. While loading it holds the RAM in wide mode (`mode`=1); once done it releases the RAM to byte-mode CPU access.

## Interface

Parameters:
- `WORDS`, 128, number of 64-bit words per load; legal range 1..128.
- `ADDR_W`, 7, word address width; fixed to match the 128-word RAM.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — begin a load; sampled only in IDLE.
- `in_valid` in 1 — byte available on `in_data`.
- `in_data` in 8 — stream byte.
- `in_ready` out 1 — loader accepts a byte this cycle.
- `mode` out 1 — drives the RAM `mode` input; 1 = wide external write path.
- `we` out 1 — drives the RAM `we` input.
- `ext_addr` out ADDR_W — drives the RAM external word address.
- `ext_data` out 64 — drives the RAM external write data.
- `busy` out 1 — high from the start acceptance until the cycle of `done`.
- `done` out 1 — one-cycle pulse after the last word write.
- `checksum` out 8 — sum of loaded bytes (see Configuration).

## Operation

- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE: `in_ready`=0, `mode`=0, `we`=0. When `start`=1, go to FILL, clear byte counter (3 bit), word address and checksum.
- FILL: `in_ready`=1, `mode`=1. Each handshake (`in_valid`&`in_ready`) does `shreg <= {shreg[55:0], in_data}` and increments the byte counter. On the handshake with byte count 7 (the eighth byte), go to WRITE.
- WRITE: exactly one cycle. `we`=1, `mode`=1, `ext_data`=packed word, `ext_addr`=current word address, `in_ready`=0. If the address is `WORDS`-1, go to DONE. Otherwise increment the address and go to FILL.
- DONE: one cycle. `done`=1, `mode`=1, `we`=0, `in_ready`=0. Then go to IDLE.
- `start` outside IDLE is ignored.
- `in_valid` outside FILL is ignored. Those bytes are not consumed.
- Byte order: stream byte k of a word lands in bits [63-8k -: 8], so RAM byte-mode block_position k reads it back.
- Address never wraps within a load. The load terminates at `WORDS`-1.
- Reset during a load:
  - Returns to IDLE immediately.
  - All outputs take their reset values.
  - The partial word is discarded.
  - Words already written stay in the RAM.

## Timing

- Reset values: `in_ready`=0, `mode`=0, `we`=0, `ext_addr`=0, `ext_data`=0, `busy`=0, `done`=0, `checksum`=0.
- All outputs are registered or decoded from the state register. There is no combinational path from `in_valid` to `in_ready`.
- `start` sampled high at edge T: FILL and `in_ready`=1 from the cycle after T.
- Eighth byte accepted at edge N: `we`=1 for the cycle between edges N and N+1. The RAM captures the word at edge N+1.
- Each word costs one bubble cycle (WRITE). With continuous `in_valid`, a full load takes 1 + 9·`WORDS` + 1 cycles from start to the end of `done`.
- `ext_data`/`ext_addr` remain stable for the whole WRITE cycle.
- `in_valid` gaps stall FILL indefinitely. There is no timeout.

## Configuration

- `RAM_LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates the mod-256 sum of every accepted byte.
  - It is cleared when `start` is accepted.
  - Its final value is valid from the DONE cycle and held until the next start or reset.
- Not defined: no accumulator is built and `checksum` is tied to 0.

## Test plan

- Reset mid-FILL after 3 bytes, then start again and load 8 bytes 0x10..0x17 -> one write only, `ext_addr`=0, `ext_data`=0x1011121314151617, no trace of the earlier bytes.
- `WORDS`=2, continuous bytes 0x00..0x0F -> writes 0x0001020304050607 at addr 0 and 0x08090A0B0C0D0E0F at addr 1, then `done` pulses one cycle. With the macro defined, `checksum`=0x78.
- Random `in_valid` gaps during a full 128-word load of byte value (i mod 256) -> every word correct, `ext_addr` runs 0..127 without wrap, `in_ready` is low in each WRITE cycle, and there are exactly 128 `we` pulses.
- `start` pulsed during FILL and DONE -> ignored. `busy` stays high and the address is not reset.
- Read-back: after the load, set `mode`=0 and read byte address 0x009 through the RAM byte port -> returns the 10th streamed byte.
- Macro undefined -> `checksum` reads 0 throughout; all other behaviour is identical.
